// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg
// ID->EX pipeline register for the 8-bit RISC-V datapath.
// It holds one instruction slot between the ID and EX stages. ID hands over an
// instruction with a valid/ready handshake. EX can stall the slot. A flush
// turns the slot into a bubble. A saturating counter records the idle cycles
// that EX sees.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   id_valid / id_ready      ID-side handshake (id_ready is combinational)
//   id_pc, id_rs1_data,
//   id_rs2_data, id_imm_ext  ID-stage data fields (DATA_W)
//   id_rd                    destination register index (REG_ADDR_W)
//   id_alu_op                ALU opcode (3 bits)
//   id_ctrl                  {alu_src,mem_read,mem_write,reg_write,mem_to_reg}
//   flush                    kill the slot (branch taken / exception)
//   ex_ready / ex_valid      EX-side handshake
//   ex_*                     registered copies of the id_* fields
//   cnt_clr                  synchronous clear of bubble_cnt
//   bubble_cnt               saturating count of edges with EX ready but idle
// -----------------------------------------------------------------------------
module id_ex_pipe_reg #(
   parameter int DATA_W     = 8,
   parameter int REG_ADDR_W = 3,
   parameter int CNT_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   output logic                  id_ready,
   input  logic [DATA_W-1:0]     id_pc,
   input  logic [DATA_W-1:0]     id_rs1_data,
   input  logic [DATA_W-1:0]     id_rs2_data,
   input  logic [DATA_W-1:0]     id_imm_ext,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [2:0]            id_alu_op,
   input  logic [4:0]            id_ctrl,
   input  logic                  flush,
   input  logic                  ex_ready,
   output logic                  ex_valid,
   output logic [DATA_W-1:0]     ex_pc,
   output logic [DATA_W-1:0]     ex_rs1_data,
   output logic [DATA_W-1:0]     ex_rs2_data,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [2:0]            ex_alu_op,
   output logic [4:0]            ex_ctrl,
   input  logic                  cnt_clr,
   output logic [CNT_W-1:0]      bubble_cnt
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam int               REG_WRITE_BIT = 1;

   state_t                  state_q, state_d;
   logic [DATA_W-1:0]       pc_q, pc_d;
   logic [DATA_W-1:0]       rs1_q, rs1_d;
   logic [DATA_W-1:0]       rs2_q, rs2_d;
   logic [DATA_W-1:0]       imm_q, imm_d;
   logic [REG_ADDR_W-1:0]   rd_q, rd_d;
   logic [2:0]              alu_op_q, alu_op_d;
   logic [4:0]              ctrl_q, ctrl_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic                    load;
   logic [4:0]              ctrl_in;

   // The slot can take a new entry when it is empty, or when EX consumes the
   // current entry on the same edge. This lets loads run back-to-back.
   assign id_ready = (state_q == EMPTY) | ex_ready;
   assign load     = id_valid & id_ready & ~flush;

   // A write to x0 must never reach the regfile, so reg_write is dropped here.
   always_comb begin
      ctrl_in = id_ctrl;
      if (id_rd == '0) begin
         ctrl_in[REG_WRITE_BIT] = 1'b0;
      end
   end

   // Next-state logic. Priority is flush > load > drain > hold.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      imm_d    = imm_q;
      rd_d     = rd_q;
      alu_op_d = alu_op_q;
      ctrl_d   = ctrl_q;

      if (flush) begin
         // Data fields keep their values. Only the fields that could cause
         // side effects are zeroed.
         state_d  = EMPTY;
         ctrl_d   = '0;
         alu_op_d = '0;
      end else if (load) begin
         state_d  = FULL;
         pc_d     = id_pc;
         rs1_d    = id_rs1_data;
         rs2_d    = id_rs2_data;
         imm_d    = id_imm_ext;
         rd_d     = id_rd;
         alu_op_d = id_alu_op;
         ctrl_d   = ctrl_in;
      end else if ((state_q == FULL) && ex_ready) begin
         // Drain: the slot becomes a bubble. ctrl is zeroed so that an empty
         // slot can never cause a memory or regfile write.
         state_d = EMPTY;
         ctrl_d  = '0;
      end
   end

   // Bubble counter. It counts edges where EX is ready but has nothing to
   // take. It ignores flush. A clear takes priority over an increment.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (ex_ready && (state_q == EMPTY) && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         pc_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         imm_q    <= '0;
         rd_q     <= '0;
         alu_op_q <= '0;
         ctrl_q   <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         imm_q    <= imm_d;
         rd_q     <= rd_d;
         alu_op_q <= alu_op_d;
         ctrl_q   <= ctrl_d;
         cnt_q    <= cnt_d;
      end
   end

   assign ex_valid    = (state_q == FULL);
   assign ex_pc       = pc_q;
   assign ex_rs1_data = rs1_q;
   assign ex_rs2_data = rs2_q;
   assign ex_imm      = imm_q;
   assign ex_rd       = rd_q;
   assign ex_alu_op   = alu_op_q;
   assign ex_ctrl     = ctrl_q;
   assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipe_reg
// Directed bench for id_ex_pipe_reg. Inputs are driven 1 time unit after the
// rising edge. Outputs are checked at that same point, after the edge has
// settled.
// -----------------------------------------------------------------------------
module tb_id_ex_pipe_reg;

   logic       clk;
   logic       rst_n;
   logic       id_valid;
   logic       id_ready;
   logic [7:0] id_pc, id_rs1_data, id_rs2_data, id_imm_ext;
   logic [2:0] id_rd;
   logic [2:0] id_alu_op;
   logic [4:0] id_ctrl;
   logic       flush;
   logic       ex_ready;
   logic       ex_valid;
   logic [7:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [2:0] ex_rd;
   logic [2:0] ex_alu_op;
   logic [4:0] ex_ctrl;
   logic       cnt_clr;
   logic [7:0] bubble_cnt;

   int checks   = 0;
   int failures = 0;

   id_ex_pipe_reg #(.DATA_W(8), .REG_ADDR_W(3), .CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_pc       (id_pc),
      .id_rs1_data (id_rs1_data),
      .id_rs2_data (id_rs2_data),
      .id_imm_ext  (id_imm_ext),
      .id_rd       (id_rd),
      .id_alu_op   (id_alu_op),
      .id_ctrl     (id_ctrl),
      .flush       (flush),
      .ex_ready    (ex_ready),
      .ex_valid    (ex_valid),
      .ex_pc       (ex_pc),
      .ex_rs1_data (ex_rs1_data),
      .ex_rs2_data (ex_rs2_data),
      .ex_imm      (ex_imm),
      .ex_rd       (ex_rd),
      .ex_alu_op   (ex_alu_op),
      .ex_ctrl     (ex_ctrl),
      .cnt_clr     (cnt_clr),
      .bubble_cnt  (bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".ex_valid"},   32'(ex_valid),    32'h0);
      chk({tag, ".ex_pc"},      32'(ex_pc),       32'h0);
      chk({tag, ".ex_rs1"},     32'(ex_rs1_data), 32'h0);
      chk({tag, ".ex_rs2"},     32'(ex_rs2_data), 32'h0);
      chk({tag, ".ex_imm"},     32'(ex_imm),      32'h0);
      chk({tag, ".ex_rd"},      32'(ex_rd),       32'h0);
      chk({tag, ".ex_alu_op"},  32'(ex_alu_op),   32'h0);
      chk({tag, ".ex_ctrl"},    32'(ex_ctrl),     32'h0);
      chk({tag, ".bubble_cnt"}, 32'(bubble_cnt),  32'h0);
   endtask

   initial begin
      rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0; cnt_clr = 1'b0;
      id_pc = 8'h0; id_rs1_data = 8'h0; id_rs2_data = 8'h0; id_imm_ext = 8'h0;
      id_rd = 3'd0; id_alu_op = 3'd0; id_ctrl = 5'd0;

      // Reset state
      step(); step();
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Back-to-back loads with imm F5 (sign-extended 6'h35).
      // The first edge sees an empty slot with ex_ready=1, which counts one bubble.
      id_valid = 1'b1; ex_ready = 1'b1; id_imm_ext = 8'hF5;
      id_rd = 3'd2; id_alu_op = 3'd5; id_ctrl = 5'b10011;
      id_rs1_data = 8'hA1; id_rs2_data = 8'hB2;
      for (int i = 0; i < 4; i++) begin
         id_pc = 8'h10 + 8'(i);
         step();
         $display("load pc=%0h -> ex_pc=%0h ex_imm=%0h ex_valid=%0b", id_pc, ex_pc, ex_imm, ex_valid);
         chk($sformatf("b2b.ex_pc[%0d]", i),    32'(ex_pc),    32'h10 + i);
         chk($sformatf("b2b.ex_valid[%0d]", i), 32'(ex_valid), 32'h1);
      end
      chk("b2b.ex_imm",     32'(ex_imm),      32'hF5);
      chk("b2b.ex_rs1",     32'(ex_rs1_data), 32'hA1);
      chk("b2b.ex_rs2",     32'(ex_rs2_data), 32'hB2);
      chk("b2b.ex_alu_op",  32'(ex_alu_op),   32'h5);
      chk("b2b.ex_ctrl",    32'(ex_ctrl),     32'h13);
      chk("b2b.ex_rd",      32'(ex_rd),       32'h2);
      chk("b2b.bubble_cnt", 32'(bubble_cnt),  32'h1);

      // Stall: EX not ready for 3 cycles while ID keeps offering.
      ex_ready = 1'b0; id_pc = 8'h20; id_imm_ext = 8'h07;
      #1;
      chk("stall.id_ready", 32'(id_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         $display("stall cycle %0d ex_pc=%0h ex_valid=%0b", i, ex_pc, ex_valid);
         chk($sformatf("stall.ex_pc[%0d]", i), 32'(ex_pc), 32'h13);
      end
      chk("stall.ex_imm",   32'(ex_imm),   32'hF5);
      chk("stall.ex_valid", 32'(ex_valid), 32'h1);
      ex_ready = 1'b1;
      #1;
      chk("unstall.id_ready", 32'(id_ready), 32'h1);
      step();
      $display("unstall ex_pc=%0h ex_imm=%0h", ex_pc, ex_imm);
      chk("unstall.ex_pc",  32'(ex_pc),  32'h20);
      chk("unstall.ex_imm", 32'(ex_imm), 32'h07);

      // A flush with a simultaneous id_valid drops the input. Data fields hold.
      flush = 1'b1; ex_ready = 1'b0; id_pc = 8'h30;
      step();
      $display("flush ex_valid=%0b ex_ctrl=%0h ex_pc=%0h", ex_valid, ex_ctrl, ex_pc);
      chk("flush.ex_valid",  32'(ex_valid),  32'h0);
      chk("flush.ex_ctrl",   32'(ex_ctrl),   32'h0);
      chk("flush.ex_alu_op", 32'(ex_alu_op), 32'h0);
      chk("flush.ex_pc",     32'(ex_pc),     32'h20);
      flush = 1'b0; id_pc = 8'h31;
      #1;
      chk("postflush.id_ready", 32'(id_ready), 32'h1);
      step();
      $display("postflush load ex_pc=%0h ex_valid=%0b", ex_pc, ex_valid);
      chk("postflush.ex_valid", 32'(ex_valid), 32'h1);
      chk("postflush.ex_pc",    32'(ex_pc),    32'h31);

      // x0 rule
      ex_ready = 1'b1; id_rd = 3'd0; id_ctrl = 5'b00010; id_pc = 8'h40;
      step();
      $display("x0 load ex_rd=%0d ex_ctrl=%0b", ex_rd, ex_ctrl);
      chk("x0.ex_ctrl",  32'(ex_ctrl),  32'h0);
      chk("x0.ex_valid", 32'(ex_valid), 32'h1);
      id_rd = 3'd3; id_pc = 8'h41;
      step();
      $display("rd3 load ex_rd=%0d ex_ctrl=%0b", ex_rd, ex_ctrl);
      chk("rd3.ex_ctrl", 32'(ex_ctrl), 32'h02);
      chk("rd3.ex_rd",   32'(ex_rd),   32'h3);

      // Drain to EMPTY. No bubble is counted on the draining edge.
      id_valid = 1'b0;
      step();
      $display("drain ex_valid=%0b ex_ctrl=%0h ex_pc=%0h", ex_valid, ex_ctrl, ex_pc);
      chk("drain.ex_valid",   32'(ex_valid),   32'h0);
      chk("drain.ex_ctrl",    32'(ex_ctrl),    32'h0);
      chk("drain.ex_pc",      32'(ex_pc),      32'h41);
      chk("drain.bubble_cnt", 32'(bubble_cnt), 32'h1);

      // Bubble counter saturation. The count starts from 1.
      for (int i = 0; i < 10; i++) step();
      chk("bubble.after10", 32'(bubble_cnt), 32'd11);
      for (int i = 0; i < 260; i++) step();
      $display("bubble saturated bubble_cnt=%0d", bubble_cnt);
      chk("bubble.sat", 32'(bubble_cnt), 32'd255);
      step();
      chk("bubble.sat_hold", 32'(bubble_cnt), 32'd255);
      cnt_clr = 1'b1;
      step();
      $display("cnt_clr bubble_cnt=%0d", bubble_cnt);
      chk("bubble.clr", 32'(bubble_cnt), 32'd0);
      cnt_clr = 1'b0;
      step();
      chk("bubble.restart", 32'(bubble_cnt), 32'd1);

      // Asynchronous reset while FULL with ex_ctrl=1F
      id_valid = 1'b1; id_rd = 3'd5; id_ctrl = 5'h1F; id_pc = 8'h55; ex_ready = 1'b0;
      step();
      chk("prereset.ex_ctrl", 32'(ex_ctrl), 32'h1F);
      #2;
      rst_n = 1'b0;
      #1;
      $display("async reset ex_valid=%0b ex_ctrl=%0h bubble_cnt=%0d", ex_valid, ex_ctrl, bubble_cnt);
      chk_all_zero("areset");
      chk("areset.id_ready", 32'(id_ready), 32'h1);

      // The first edge after reset is released accepts a load.
      step();
      rst_n = 1'b1;
      id_pc = 8'h66;
      step();
      $display("post-reset load ex_pc=%0h ex_valid=%0b", ex_pc, ex_valid);
      chk("postreset.ex_valid", 32'(ex_valid), 32'h1);
      chk("postreset.ex_pc",    32'(ex_pc),    32'h66);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
